mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/project_pkg.sv | 23 ++
 rtl/mem_responder_if.sv | 41 ++++
 rtl/mem_responder_mem_array.sv | 32 +++
 rtl/mem_responder.sv | 126 ++++++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/project_pkg.sv
// Shared types for the memory responder slice: data word, wait count
// and responder FSM state encoding.
package project_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int WORD_W    = 8;
    localparam int WCNT_W    = 3;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [WCNT_W-1:0] wcnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } e_mem_state;

    // Index width for a power-of-two byte array of the given depth.
    function automatic int idx_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath (master) and the memory
// responder (slave).
interface mem_responder_if
    import project_pkg::*;
;

    logic  req;
    logic  we;
    word_t addr;
    word_t wdata;
    wcnt_t wait_cfg;
    logic  wait_ld;
    word_t rdata;
    logic  ready;
    logic  busy;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        output wait_cfg,
        output wait_ld,
        input  rdata,
        input  ready,
        input  busy
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        input  wait_cfg,
        input  wait_ld,
        output rdata,
        output ready,
        output busy
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Byte storage for the responder: synchronous write, combinational read,
// no reset. Address wraps modulo DEPTH.
module mem_array
    import project_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH
) (
    input  logic  clk,
    input  logic  we,
    input  word_t addr,
    input  word_t wdata,
    output word_t rdata
);

    localparam int AW = idx_bits(DEPTH);

    word_t          mem [DEPTH];
    logic  [AW-1:0] idx;
    logic           unused_addr;

    assign idx         = addr[AW-1:0];
    assign unused_addr = ^addr;
    assign rdata       = mem[idx];

    // Commit a write at the edge that ends the response cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: IDLE/WAIT/RESP handshake FSM in front of a byte array.
// Optional programmable wait states are enabled with MEM_WAIT_EN.
module mem_responder
    import project_pkg::*;
#(
    parameter int    DEPTH    = MEM_DEPTH,
    parameter wcnt_t WAIT_RST = 3'd0
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    e_mem_state state_q;
    e_mem_state state_d;
    wcnt_t      cnt_q;
    wcnt_t      cnt_d;
    wcnt_t      wcnt;
    word_t      addr_q;
    word_t      wdata_q;
    logic       we_q;
    word_t      rdata_q;
    word_t      rdata_d;
    word_t      mem_rd;
    logic       accept;
    logic       mem_we;

`ifdef MEM_WAIT_EN
    wcnt_t wait_q;
    logic  ld_now;

    assign ld_now = (state_q == IDLE) && bus.wait_ld;

    // A load in the same idle cycle as a request applies to that request.
    assign wcnt = ld_now ? bus.wait_cfg : wait_q;

    // Wait-state register, writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= WAIT_RST;
        end else if (ld_now) begin
            wait_q <= bus.wait_cfg;
        end
    end
`else
    wcnt_t unused_wait;
    logic  unused_ld;

    assign wcnt        = '0;
    assign unused_wait = WAIT_RST ^ bus.wait_cfg;
    assign unused_ld   = bus.wait_ld;
`endif

    // Next-state, handshake outputs and memory write strobe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        mem_we    = 1'b0;
        rdata_d   = rdata_q;
        bus.ready = 1'b0;
        bus.busy  = (state_q != IDLE);
        bus.rdata = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    accept = 1'b1;
                    if (wcnt != '0) begin
                        state_d = WAIT;
                        cnt_d   = wcnt;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= wcnt_t'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.ready = 1'b1;
                state_d   = IDLE;
                mem_we    = we_q;
                rdata_d   = we_q ? wdata_q : mem_rd;
                bus.rdata = rdata_d;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, captured request and held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                we_q    <= bus.we;
            end
        end
    end

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rd)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default-depth and DEPTH=16 instances,
// wait-state cases when MEM_WAIT_EN is defined.
module tb_mem_responder;
    import project_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_responder_if b0 ();
    mem_responder_if b1 ();

    mem_responder u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    mem_responder #(
        .DEPTH (16)
    ) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit s, input logic r, input logic w,
                         input word_t a, input word_t d);
        if (s) begin
            b1.req = r; b1.we = w; b1.addr = a; b1.wdata = d;
        end else begin
            b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? b1.ready : b0.ready;
    endfunction

    function automatic logic bsy(input bit s);
        return s ? b1.busy : b0.busy;
    endfunction

    function automatic word_t rdat(input bit s);
        return s ? b1.rdata : b0.rdata;
    endfunction

    task automatic xfer(input string tag, input bit s, input logic w,
                        input word_t a, input word_t d,
                        input word_t exp_rd, input int exp_lat);
        int    lat  = 0;
        int    nb   = 0;
        bit    seen = 1'b0;
        word_t rd   = '0;
        @(posedge clk); #1;
        drive(s, 1'b1, w, a, d);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bsy(s)) nb++;
            if (rdy(s)) begin
                seen = 1'b1;
                rd   = rdat(s);
            end
        end
        drive(s, 1'b0, 1'b0, 8'h00, 8'h00);
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_rdata"}, 32'(rd), 32'(exp_rd));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy"}, 32'(nb), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_after"}, {30'd0, bsy(s), rdy(s)}, 32'd0);
    endtask

    task automatic cont(input string tag, input int w, input int n);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_%0d", tag, k), 32'(rdy(1'b0)),
                  32'((k >= 1 + w) && ((k - 1 - w) % (2 + w) == 0)));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (w + 3) @(negedge clk);
    endtask

    word_t wa [4] = '{8'hFF, 8'h00, 8'h20, 8'h05};
    word_t wd [4] = '{8'h55, 8'hAA, 8'h33, 8'h11};

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        b0.wait_cfg = '0; b0.wait_ld = 1'b0;
        b1.wait_cfg = '0; b1.wait_ld = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(b0.ready), 32'd0);
        check("rst_busy", 32'(b0.busy), 32'd0);
        check("rst_rdata", 32'(b0.rdata), 32'h00);
        check("rst_rdata16", 32'(b1.rdata), 32'h00);
        rst = 1'b0;

        xfer("wr10", 1'b0, 1'b1, 8'h10, 8'h7A, 8'h7A, 1);
        xfer("rd10", 1'b0, 1'b0, 8'h10, 8'h00, 8'h7A, 1);
        @(negedge clk);
        check("rdata_hold", 32'(b0.rdata), 32'h7A);

        for (int i = 0; i < 4; i++)
            xfer($sformatf("wr_%0d", i), 1'b0, 1'b1, wa[i], wd[i], wd[i], 1);
        for (int i = 0; i < 4; i++)
            xfer($sformatf("rd_%0d", i), 1'b0, 1'b0, wa[i], 8'h00, wd[i], 1);

        // In-flight request must ignore later input changes.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b1, 8'h20, 8'hEE);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (b0.ready) begin
                    seen = 1'b1;
                    check("flight_rdata", 32'(b0.rdata), 32'h7A);
                end
                if (!seen) @(posedge clk);
            end
            check("flight_seen", 32'(seen), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        xfer("flight_rd20", 1'b0, 1'b0, 8'h20, 8'h00, 8'h33, 1);

        // Reset in the middle of a write aborts it.
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 8'h05, 8'hFD);
`ifdef MEM_WAIT_EN
        b0.wait_cfg = 3'd2; b0.wait_ld = 1'b1;
`endif
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
        b0.wait_cfg = '0; b0.wait_ld = 1'b0;
        check("abort_busy_pre", 32'(b0.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(b0.ready), 32'd0);
        check("abort_busy", 32'(b0.busy), 32'd0);
        check("abort_rdata", 32'(b0.rdata), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        xfer("abort_rd05", 1'b0, 1'b0, 8'h05, 8'h00, 8'h11, 1);

        xfer("d16_wr23", 1'b1, 1'b1, 8'h23, 8'h8A, 8'h8A, 1);
        xfer("d16_rd03", 1'b1, 1'b0, 8'h03, 8'h00, 8'h8A, 1);

        cont("cont_w0", 0, 10);

`ifdef MEM_WAIT_EN
        @(posedge clk); #1;
        b0.wait_cfg = 3'd3; b0.wait_ld = 1'b1;
        @(posedge clk); #1;
        b0.wait_cfg = '0; b0.wait_ld = 1'b0;
        xfer("w3_rd10", 1'b0, 1'b0, 8'h10, 8'h00, 8'h7A, 4);
        xfer("w3_wr40", 1'b0, 1'b1, 8'h40, 8'hC3, 8'hC3, 4);
        xfer("w3_rd40", 1'b0, 1'b0, 8'h40, 8'h00, 8'hC3, 4);
        cont("cont_w3", 3, 15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
